// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- BIST sequencer: FSM states and per-element tables.
package mbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int MARCH_NUM_ELEM = 6;
    localparam int ELEM_W         = 3;
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(MARCH_NUM_ELEM - 1);

    // Bit e of each table describes March element e; bits 6 and 7 are padding so
    // that an index one past the last element reads as 0.
    // March C-: up(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) up(r0)
    localparam logic [7:0] ELEM_DIR_DN  = 8'b0001_1000;  // 1 = descending addresses
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;  // 1 = read then write per address
    localparam logic [7:0] ELEM_OP0_WR  = 8'b0000_0001;  // first op is a write
    localparam logic [7:0] ELEM_OP1_WR  = 8'b0001_1110;  // second op is a write
    localparam logic [7:0] ELEM_RD_ONE  = 8'b0001_0100;  // read expects all-ones
    localparam logic [7:0] ELEM_WR_ONE  = 8'b0000_1010;  // write stores all-ones

    function automatic logic op_is_write(input logic [ELEM_W-1:0] elem, input logic op);
        return op ? ELEM_OP1_WR[elem] : ELEM_OP0_WR[elem];
    endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Read-data checker: delays the expected value by the memory read latency,
// compares against rdata and keeps only the first mismatch.
module mbist_cmp_pipe
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_exp,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [ELEM_W-1:0]     push_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ELEM_W-1:0]     fail_elem,
    output logic [DATA_WIDTH-1:0] fail_rdata
);

    logic                  s1_vld, s2_vld;
    logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
    logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
    logic [ELEM_W-1:0]     s1_elem, s2_elem;
    logic                  captured_q;
    logic                  mismatch;

    // Two-deep delay line so stage 2 lines up with rdata of the same read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_exp  <= '0;
            s2_exp  <= '0;
            s1_addr <= '0;
            s2_addr <= '0;
            s1_elem <= '0;
            s2_elem <= '0;
        end else begin
            s1_vld  <= push;
            s1_exp  <= push_exp;
            s1_addr <= push_addr;
            s1_elem <= push_elem;
            s2_vld  <= s1_vld;
            s2_exp  <= s1_exp;
            s2_addr <= s1_addr;
            s2_elem <= s1_elem;
        end
    end

    // Compare the aligned expected value with the returning read data.
    always_comb begin
        mismatch = s2_vld && (rdata != s2_exp);
    end

    // Registered first-fail capture; later mismatches leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass       <= 1'b0;
            captured_q <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_rdata <= '0;
        end else if (clear) begin
            pass       <= 1'b1;
            captured_q <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_rdata <= '0;
        end else if (mismatch && !captured_q) begin
            pass       <= 1'b0;
            captured_q <= 1'b1;
            fail_addr  <= s2_addr;
            fail_elem  <= s2_elem;
            fail_rdata <= rdata;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer for the single-port fault_mem macro: FSM, element/address/op
// counters, wdata look-ahead for the macro's registered write data, and result capture.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_rdata,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY);

    state_t                state_q, state_d;
    logic [ELEM_W-1:0]     elem_q, next_elem;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  op_q;
    logic [1:0]            drain_q;
    logic                  cur_wr, last_op, last_addr, elem_end;
    logic                  accept, rd_issue;

    // Decode where the current op sits inside its element.
    always_comb begin
        cur_wr    = op_is_write(elem_q, op_q);
        last_op   = op_q || !ELEM_TWO_OPS[elem_q];
        last_addr = ELEM_DIR_DN[elem_q] ? (addr_q == '0) : (addr_q == ADDR_LAST);
        elem_end  = last_op && last_addr;
        next_elem = elem_end ? elem_q + ELEM_W'(1) : elem_q;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and memory/handshake outputs.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        write_read = 1'b0;
        address    = '0;
        wdata      = '0;
        rd_issue   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    accept  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                busy    = 1'b1;
                wdata   = {DATA_WIDTH{ELEM_WR_ONE[0]}};
                state_d = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                address    = addr_q;
                write_read = cur_wr;
                rd_issue   = !cur_wr;
                // The macro registers wdata, so present the next op's data now.
                wdata      = {DATA_WIDTH{ELEM_WR_ONE[next_elem]}};
                if (elem_end && elem_q == LAST_ELEM) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == 2'd2) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Op/address/element walk through the March sequence, plus drain timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_q  <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            drain_q <= '0;
        end else if (accept) begin
            elem_q  <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            drain_q <= '0;
        end else if (state_q == RUN) begin
            if (!last_op) begin
                op_q <= 1'b1;
            end else begin
                op_q <= 1'b0;
                if (last_addr) begin
                    elem_q <= next_elem;
                    addr_q <= ELEM_DIR_DN[next_elem] ? ADDR_LAST : '0;
                end else if (ELEM_DIR_DN[elem_q]) begin
                    addr_q <= addr_q - ADDR_WIDTH'(1);
                end else begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end
        end else if (state_q == DRAIN) begin
            drain_q <= drain_q + 2'd1;
        end
    end

    mbist_cmp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .push       (rd_issue),
        .push_exp   ({DATA_WIDTH{ELEM_RD_ONE[elem_q]}}),
        .push_addr  (addr_q),
        .push_elem  (elem_q),
        .rdata      (rdata),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_rdata (fail_rdata)
    );

endmodule
